// File: rtl/dsd_scan_ctrl_if.sv
// Bundle between a digit-writing host and the seven-segment scan controller.
// No valid/ready here: wr_en and commit are single-cycle strobes sampled on every rising clock edge.
interface dsd_scan_ctrl_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_blank;
  logic       commit;
  logic [3:0] num;
  logic [2:0] sel;
  logic       active;
  logic       commit_pending;
  logic       frame_done;
  logic       dbg_state;

  modport master (
    output wr_en, wr_addr, wr_data, wr_blank, commit,
    input  num, sel, active, commit_pending, frame_done, dbg_state
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_blank, commit,
    output num, sel, active, commit_pending, frame_done, dbg_state
  );
endinterface

// File: rtl/dsd_scan_ctrl.sv
// Eight-digit seven-segment scan controller with a double-buffered digit bank
// that is swapped only at frame boundaries, plus blank gaps between digits.
module dsd_scan_ctrl #(
  parameter int DWELL = 100000,
  parameter int BLANK = 1000
) (
  input logic            clk,
  input logic            reset,
  dsd_scan_ctrl_if.slave bus
);
  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXC);

  typedef enum logic {S_BLANK = 1'b0, S_SHOW = 1'b1} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_shadow [8];
  logic [4:0]    r_disp   [8];
  logic [3:0]    r_num;
  logic [2:0]    r_sel;
  logic          r_active;
  logic          r_pending;
  logic          r_frame_done;

  logic w_blank_end;
  logic w_show_end;
  logic w_boundary;

  assign w_blank_end = (r_state == S_BLANK) && (r_cnt == CW'(BLANK - 1));
  assign w_show_end  = (r_state == S_SHOW)  && (r_cnt == CW'(DWELL - 1));
  assign w_boundary  = w_show_end && (r_sel == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_BLANK;
      r_cnt        <= '0;
      r_num        <= 4'd0;
      r_sel        <= 3'd0;
      r_active     <= 1'b0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_shadow[i] <= 5'b1_0000;
        r_disp[i]   <= 5'b1_0000;
      end
    end else begin
      r_frame_done <= 1'b0;
      if (bus.wr_en)
        r_shadow[bus.wr_addr] <= {bus.wr_blank, bus.wr_data};
      if (bus.commit)
        r_pending <= 1'b1;

      case (r_state)
        S_BLANK: begin
          if (w_blank_end) begin
            r_state  <= S_SHOW;
            r_cnt    <= '0;
            r_num    <= r_disp[r_sel][3:0];
            r_active <= ~r_disp[r_sel][4];
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_SHOW: begin
          if (w_show_end) begin
            r_state  <= S_BLANK;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_sel    <= r_sel + 3'd1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_BLANK;
          r_cnt   <= '0;
        end
      endcase

      // Nonblocking copy: a write landing in this same cycle stays in shadow only.
      if (w_boundary) begin
        r_frame_done <= 1'b1;
        if (r_pending || bus.commit) begin
          for (int i = 0; i < 8; i++)
            r_disp[i] <= r_shadow[i];
          r_pending <= 1'b0;
        end
      end
    end
  end

  assign bus.num            = r_num;
  assign bus.sel            = r_sel;
  assign bus.active         = r_active;
  assign bus.commit_pending = r_pending;
  assign bus.frame_done     = r_frame_done;
  assign bus.dbg_state      = r_state;
endmodule

// File: doc/dsd_scan_ctrl.md
# dsd_scan_ctrl

Time-multiplexed scan controller for the 8-digit seven-segment display path. It holds eight 4-bit digit values plus per-digit blank flags in a double-buffered register set and steps the decoder's 3-bit digit select through all eight positions. It drives the decoder's value input and an enable that stays low during inter-digit blank gaps to prevent ghosting. Writes land in a shadow bank and reach the display bank only at a frame boundary, so a frame never shows a mix of old and new digits.

## Interface
- DWELL, 100000: clock cycles each digit is shown (active); legal range ≥ 2.
- BLANK, 1000: clock cycles of dark gap before each digit; legal range ≥ 1.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset. One clock, and reset is asynchronous and active-high.
- wr_en  in  1  write strobe into the shadow bank.
- wr_addr  in  3  shadow digit index.
- wr_data  in  4  hex value to store.
- wr_blank  in  1  blank flag stored with the digit; 1 means the digit stays dark.
- commit  in  1  request to copy shadow to display at the next frame boundary.
- num  out  4  value for the decoder (registered).
- sel  out  3  digit select for the decoder (registered).
- active  out  1  decoder/anode enable (registered).
- commit_pending  out  1  a commit has been requested but not yet applied.
- frame_done  out  1  one-cycle pulse after each full 8-digit frame.

## Operation
- Storage: shadow[0..7] and disp[0..7], each entry {blank, value[3:0]}. Reset value of every entry is blank=1, value=0.
- Writes: when wr_en=1, shadow[wr_addr] <= {wr_blank, wr_data} every cycle. Writes never touch disp directly.
- FSM states: BLANK and SHOW. A cycle counter cnt resets to 0 on every state change.
  - BLANK: active=0. When cnt==BLANK-1, go to SHOW. On that edge, num <= disp[sel].value and active <= ~disp[sel].blank.
  - SHOW: num and active are held. When cnt==DWELL-1, go to BLANK. On that edge, active <= 0 and sel <= sel+1, wrapping 7→0.
- Frame boundary: the SHOW→BLANK edge taken while sel==7.
  - On that edge, frame_done <= 1 for one cycle.
  - If commit_pending==1 or commit==1 in that cycle, then disp <= shadow (all 8 entries) and commit_pending <= 0.
- Commit outside the boundary cycle sets commit_pending <= 1. Holding commit high for several cycles has the same effect as a single pulse.
- Write in the boundary cycle: disp receives the pre-write shadow contents. The new write remains in shadow until the next commit.
- Reset values:
  - Outputs: num=0, sel=0, active=0, commit_pending=0, frame_done=0.
  - FSM: BLANK with cnt=0.
  - All digits blank.

## Timing
- Digit period is DWELL+BLANK cycles. Frame period is 8·(DWELL+BLANK) cycles.
- After reset deasserts, the first BLANK→SHOW edge is the BLANK-th rising edge.
- active is high for exactly DWELL consecutive cycles per non-blank digit, then low for BLANK cycles.
- sel and num change only on FSM edges, never while active=1.
- A commit takes effect on the boundary edge. The first digit using new data is digit 0, which shows it after the following BLANK gap.
- Worst-case latency from commit to visible data is one frame plus BLANK cycles.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous). Any pending commit is discarded and shadow contents are lost.

## Test plan
Use DWELL=4 and BLANK=2 for all scenarios.
- Reset, then run 48 cycles with no writes: sel steps 0→7 every 6 cycles, active stays 0 throughout, num=0, frame_done pulses on cycle 48.
- Write shadow[k]={0,k+1} for k=0..7, then pulse commit mid-frame: commit_pending=1 until the boundary. In the next frame, digit k shows num=k+1 with active high for 4 cycles and low for 2.
- Write shadow[2]={0,F} without commit: disp is unchanged over two frames (sel=2 still shows 3). Then commit: the following frame shows F at sel=2.
- Set shadow[3] blank=1 and commit: during sel=3 SHOW, active=0. All other digits are unaffected.
- Assert commit and wr_en (addr 0, data A) in the boundary cycle: the next frame shows the old digit-0 value, shadow[0]=A, and commit_pending=0.
- Assert reset during SHOW of sel=5 with commit_pending=1: outputs go to 0 at once, commit_pending clears, and after release all digits are dark.
